// File: rtl/debug_instr_encoder.sv
// Debug command encoder: turns register/memory debug commands into short RV32I
// sequences ending in a NOP, feeds them to the injection port, then waits for completion.
module debug_instr_encoder #(
    parameter logic [11:0] DBG_OFF = 12'h7F0,
    parameter int          SCR_A   = 31,
    parameter int          SCR_D   = 30,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_regno,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        instr_done,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic        busy
);
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [4:0]    RA       = 5'(SCR_A);
    localparam logic [4:0]    RD       = 5'(SCR_D);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] OP_RR = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_MR = 2'b10;
    localparam logic [1:0] OP_MW = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT, S_DONE} state_t;

    // Upper part rounded so that the sign-extended low 12 bits add back to v exactly.
    function automatic logic [19:0] f_hi(input logic [31:0] v);
        return v[31:12] + {19'd0, v[11]};
    endfunction

    function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction

    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [2:0] f_count(input logic [1:0] op, input logic [4:0] rn);
        logic [2:0] n;
        case (op)
            OP_RR:   n = 3'd2;
            OP_RW:   n = (rn == 5'd0) ? 3'd1 : 3'd3;
            OP_MR:   n = 3'd4;
            default: n = 3'd5;
        endcase
        return n;
    endfunction

    // Word idx of the sequence; any index past the body is the trailing NOP.
    function automatic logic [31:0] f_word(input logic [1:0] op, input logic [4:0] rn,
                                           input logic [31:0] a, input logic [31:0] d,
                                           input logic [2:0] idx);
        logic [31:0] w;
        w = NOP;
        case (op)
            OP_RR: begin
                if (idx == 3'd0) w = f_sw(rn, 5'd0, DBG_OFF);
            end
            OP_RW: begin
                if (rn != 5'd0) begin
                    case (idx)
                        3'd0:    w = f_lui(rn, f_hi(d));
                        3'd1:    w = f_addi(rn, rn, d[11:0]);
                        default: w = NOP;
                    endcase
                end
            end
            OP_MR: begin
                case (idx)
                    3'd0:    w = f_lui(RA, f_hi(a));
                    3'd1:    w = f_lw(RA, RA, a[11:0]);
                    3'd2:    w = f_sw(RA, 5'd0, DBG_OFF);
                    default: w = NOP;
                endcase
            end
            default: begin
                case (idx)
                    3'd0:    w = f_lui(RA, f_hi(a));
                    3'd1:    w = f_lui(RD, f_hi(d));
                    3'd2:    w = f_addi(RD, RD, d[11:0]);
                    3'd3:    w = f_sw(RD, RA, a[11:0]);
                    default: w = NOP;
                endcase
            end
        endcase
        return w;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_op;
    logic [4:0]      r_regno;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic [2:0]      r_idx;
    logic [TW-1:0]   r_tmo;
    logic [31:0]     r_instr_out;
    logic            r_instr_valid;
    logic            r_cmd_ready;
    logic            r_cmd_done;
    logic            r_cmd_err;
    logic            r_busy;

    logic            w_accept;
    logic            w_fire;
    logic            w_last;
    logic            w_tmo_exp;
    logic [1:0]      w_op_nxt;
    logic [4:0]      w_regno_nxt;
    logic [31:0]     w_addr_nxt;
    logic [31:0]     w_data_nxt;
    logic [2:0]      w_idx_nxt;
    logic [31:0]     w_instr_nxt;
    logic            w_valid_nxt;
    logic            w_ready_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_busy_nxt;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_fire    = r_instr_valid && instr_ready;
    assign w_last    = (r_idx == f_count(r_op, r_regno) - 3'd1);
    assign w_tmo_exp = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A completion arriving on the expiry cycle still wins: WAIT exits on either.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_fire && w_last) w_state_nxt = S_WAIT;
            S_WAIT:  if (instr_done || w_tmo_exp) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_op_nxt    = r_op;
        w_regno_nxt = r_regno;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        if (w_accept) begin
            w_op_nxt    = cmd_op;
            w_regno_nxt = cmd_regno;
            w_addr_nxt  = cmd_addr;
            w_data_nxt  = cmd_data;
            w_idx_nxt   = 3'd0;
        end else if (w_fire && !w_last) begin
            w_idx_nxt   = r_idx + 3'd1;
        end
    end

    // Outputs are precomputed from the next state so every port comes straight off a flop.
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_valid_nxt = (w_state_nxt == S_EMIT);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_err_nxt   = (r_state == S_WAIT) && (w_state_nxt == S_DONE) && !instr_done;
        w_instr_nxt = NOP;
        if (w_valid_nxt)
            w_instr_nxt = f_word(w_op_nxt, w_regno_nxt, w_addr_nxt, w_data_nxt, w_idx_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op          <= 2'd0;
            r_regno       <= 5'd0;
            r_addr        <= 32'd0;
            r_data        <= 32'd0;
            r_idx         <= 3'd0;
            r_tmo         <= '0;
            r_instr_out   <= NOP;
            r_instr_valid <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_cmd_done    <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_op          <= w_op_nxt;
            r_regno       <= w_regno_nxt;
            r_addr        <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_idx         <= w_idx_nxt;
            r_tmo         <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;
            r_instr_out   <= w_instr_nxt;
            r_instr_valid <= w_valid_nxt;
            r_cmd_ready   <= w_ready_nxt;
            r_cmd_done    <= w_done_nxt;
            r_cmd_err     <= w_err_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign cmd_ready   = r_cmd_ready;
    assign cmd_done    = r_cmd_done;
    assign cmd_err     = r_cmd_err;
    assign busy        = r_busy;

endmodule

// File: doc/debug_instr_encoder.md
# debug_instr_encoder

Debug-side instruction generator: accepts abstract debugger commands (register read/write, memory read/write), encodes each as a short RV32I instruction sequence, and feeds it word-by-word into the core's fetch-bypass injection port. This is the encoding counterpart of the core's instruction decoder. Each sequence ends with the canonical NOP (0x00000013), which the decoder flags as instruction-complete in stage 3. The block then waits for that completion, or a timeout, and reports status to the debug transport.

## Interface
Parameters:
- DBG_OFF, 12'h7F0, x0-relative offset of the debug data word; register/memory readback is stored there.
- SCR_A, 31, scratch register used for addresses.
- SCR_D, 30, scratch register used for data.
- TIMEOUT, 64, cycles to wait for completion after the trailing NOP is accepted.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 REG_READ, 01 REG_WRITE, 10 MEM_READ, 11 MEM_WRITE
- cmd_regno  in  5  target GPR
- cmd_addr  in  32  memory address
- cmd_data  in  32  write data
- instr_out  out  32  encoded instruction
- instr_valid  out  1  instr_out valid
- instr_ready  in  1  core accepts instr_out
- instr_done  in  1  one-cycle pulse from stage 3 when the injected NOP completes
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  qualified by cmd_done; 1 = timeout
- busy  out  1  high in any state except IDLE

## Operation
- States:
  - IDLE: cmd_ready=1; on cmd_valid, latch op/regno/addr/data, set idx=0, go to EMIT.
  - EMIT: present sequence word idx; when the last word (the NOP) is accepted, go to WAIT.
  - WAIT: wait for instr_done; if it arrives, go to DONE with err=0; on timeout, go to DONE with err=1.
  - DONE: pulse cmd_done for one cycle, then go to IDLE.
- Split rule, for any 32-bit value v:
  - hi(v) = (v[31:12] + v[11]) mod 2^20
  - lo(v) = v[11:0], sign-extended by the core
  - lui followed by addi/lw/sw with lo reconstructs v exactly, including v[11]=1 and the hi wrap at 0xFFFFF800 and above.
- Sequences:
  - REG_READ: sw rN,DBG_OFF(x0); NOP.
  - REG_WRITE, rN≠0: lui rN,hi(data); addi rN,rN,lo(data); NOP.
  - REG_WRITE, rN=0: NOP only.
  - MEM_READ: lui A,hi(addr); lw A,lo(addr)(A); sw A,DBG_OFF(x0); NOP.
  - MEM_WRITE: lui A,hi(addr); lui D,hi(data); addi D,D,lo(data); sw D,lo(addr)(A); NOP.
- Scratch registers A=SCR_A and D=SCR_D are clobbered; restoring them is the host's responsibility.
- Encodings (standard RV32I):
  - lui: imm20<<12 | rd<<7 | 0x37
  - addi: imm12<<20 | rs1<<15 | rd<<7 | 0x13
  - lw: imm12<<20 | rs1<<15 | 2<<12 | rd<<7 | 0x03
  - sw: imm[11:5]<<25 | rs2<<20 | rs1<<15 | 2<<12 | imm[4:0]<<7 | 0x23

## Timing
- Reset values: instr_out=0x00000013, instr_valid=0, cmd_done=0, cmd_err=0, busy=0, cmd_ready=1; state IDLE; idx and timeout counter are 0.
- Reset mid-sequence aborts immediately with no cmd_done; the remaining words are never issued.
- Outputs are registered. instr_valid rises the cycle after command acceptance.
- instr_out and instr_valid hold stable until instr_ready; idx advances only on instr_valid&&instr_ready. Back-to-back acceptance issues one word per cycle.
- Word counts: REG_READ 2, REG_WRITE 3 (1 for x0), MEM_READ 4, MEM_WRITE 5. Minimum command-to-cmd_done latency is count+3 cycles with instr_ready tied high and instr_done arriving in the first WAIT cycle.
- The timeout counter clears on entry to WAIT and counts from 0. A timeout occurs when the counter reaches TIMEOUT-1 without instr_done.
- instr_done outside WAIT is ignored. instr_done in the same cycle as timeout expiry counts as success (err=0).
- cmd_err is valid only while cmd_done=1 and is 0 otherwise.
- cmd_ready reasserts the cycle after cmd_done. A cmd_valid held during busy is not accepted.

## Test plan
- REG_WRITE x5, data 0x12345FFF, instr_ready=1, instr_done one cycle after the NOP -> words 0x123462B7, 0xFFF28293, 0x00000013; cmd_done=1, cmd_err=0.
- REG_READ x10 with default DBG_OFF -> words 0x7EA02823, 0x00000013; REG_WRITE x0 -> single word 0x00000013.
- MEM_WRITE addr 0x80000800, data 0x00000001, instr_ready toggling 1-0-1 -> five words lui x31,0x80001; lui x30,0; addi x30,x30,1; sw x30,-2048(x31); NOP. Each word stays stable while instr_ready=0, and no word is duplicated or skipped.
- MEM_READ with instr_done never asserted -> cmd_done with cmd_err=1 exactly TIMEOUT cycles after NOP acceptance; next command accepted afterwards.
- instr_done pulse in the same cycle as timeout expiry -> cmd_err=0. An instr_done pulse during EMIT has no effect.
- rst asserted after the second word of MEM_WRITE -> next cycle: instr_valid=0, instr_out=0x00000013, busy=0, no cmd_done; a new command then encodes correctly from word 0.
